// File: rtl/cla_group_carry_seq.sv
// -----------------------------------------------------------------------------
// cla_group_carry_seq
//
// Sequential carry-lookahead stage. One operation (generate vector, propagate
// vector, carry-in) is accepted over a valid/ready handshake. The carries and
// sum bits are then resolved one GROUP-bit slice per clock. Inside a slice the
// carries use a flat two-level lookahead, so there is no ripple within the
// slice. The N-bit sum and the carry-out are presented on a valid/ready output
// handshake.
//
// Parameters
//   N      operand width in bits (multiple of GROUP)
//   GROUP  bits resolved per CALC cycle (1 <= GROUP <= N)
//
// Ports
//   clk             rising-edge clock
//   rst_n           asynchronous active-low reset
//   in_valid        upstream offers a G/P/carry-in set
//   in_ready        block can accept a new operation (registered)
//   generate_value  per-bit generate  g_i = a_i & b_i
//   propagate       per-bit propagate p_i = a_i ^ b_i
//   carry_in        carry into bit 0
//   out_valid       sum / carry_out / block_prop are valid
//   out_ready       downstream accepts the result
//   sum             s_i = p_i ^ c_i
//   carry_out       carry out of bit N-1
//   block_prop      AND of all propagate bits of the accepted operation
// -----------------------------------------------------------------------------
module cla_group_carry_seq #(
    parameter int N     = 16,
    parameter int GROUP = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] generate_value,
    input  logic [N-1:0] propagate,
    input  logic         carry_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
    output logic         carry_out,
    output logic         block_prop
);

    localparam int NSL  = N / GROUP;
    localparam int IDXW = (NSL > 1) ? $clog2(NSL) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSL - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [N-1:0]      g_q, g_d;
    logic [N-1:0]      p_q, p_d;
    logic              c_q, c_d;        // running carry into the current slice
    logic [N-1:0]      sum_q, sum_d;
    logic              cout_q, cout_d;
    logic              bprop_q, bprop_d;
    logic              in_ready_q, in_ready_d;

    // Carry into bit j+1 of a slice, as a flat sum of products:
    //   c_{j+1} = g_j | p_j g_{j-1} | ... | p_j..p_1 g_0 | p_j..p_0 cin
    // Called with constant j, so each call elaborates to one AND-OR plane.
    function automatic logic la_carry(
        input logic [GROUP-1:0] g,
        input logic [GROUP-1:0] p,
        input logic             cin,
        input int               j
    );
        logic r;
        logic t;
        r = cin;
        for (int q = 0; q <= j; q++) begin
            r = r & p[q];
        end
        for (int m = 0; m <= j; m++) begin
            t = g[m];
            for (int q = m + 1; q <= j; q++) begin
                t = t & p[q];
            end
            r = r | t;
        end
        return r;
    endfunction

    // Slice views of the latched operands, selected by the slice index.
    logic [GROUP-1:0] g_slices [NSL];
    logic [GROUP-1:0] p_slices [NSL];
    logic [GROUP-1:0] g_sl;
    logic [GROUP-1:0] p_sl;
    logic [GROUP:0]   c_sl;
    logic [GROUP-1:0] s_sl;
    logic [N-1:0]     sum_upd;

    for (genvar gi = 0; gi < NSL; gi++) begin : g_slice_view
        assign g_slices[gi] = g_q[gi*GROUP +: GROUP];
        assign p_slices[gi] = p_q[gi*GROUP +: GROUP];
        // Only the slice being processed is replaced; the rest hold.
        assign sum_upd[gi*GROUP +: GROUP] =
            (idx_q == IDXW'(gi)) ? s_sl : sum_q[gi*GROUP +: GROUP];
    end

    assign g_sl    = g_slices[idx_q];
    assign p_sl    = p_slices[idx_q];
    assign c_sl[0] = c_q;

    for (genvar gi = 0; gi < GROUP; gi++) begin : g_lookahead
        assign c_sl[gi+1] = la_carry(g_sl, p_sl, c_q, gi);
    end

    assign s_sl = p_sl ^ c_sl[GROUP-1:0];

    // Next-state and datapath updates.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        g_d     = g_q;
        p_d     = p_q;
        c_d     = c_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        bprop_d = bprop_q;

        case (state_q)
            S_IDLE: begin
                // in_ready_q gates acceptance so nothing is taken on the
                // first edge after reset release, when in_ready is still 0.
                if (in_ready_q && in_valid) begin
                    g_d     = generate_value;
                    p_d     = propagate;
                    c_d     = carry_in;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                    bprop_d = &propagate;
                    idx_d   = '0;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                sum_d = sum_upd;
                c_d   = c_sl[GROUP];
                if (idx_q == LAST_IDX) begin
                    cout_d  = c_sl[GROUP];
                    idx_d   = '0;
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + IDXW'(1);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Registered ready: high in every cycle the FSM sits in IDLE.
        in_ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            g_q        <= '0;
            p_q        <= '0;
            c_q        <= 1'b0;
            sum_q      <= '0;
            cout_q     <= 1'b0;
            bprop_q    <= 1'b0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            g_q        <= g_d;
            p_q        <= p_d;
            c_q        <= c_d;
            sum_q      <= sum_d;
            cout_q     <= cout_d;
            bprop_q    <= bprop_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = (state_q == S_DONE);
    assign sum        = sum_q;
    assign carry_out  = cout_q;
    assign block_prop = bprop_q;

endmodule

// File: tb/tb_cla_group_carry_seq.sv
// -----------------------------------------------------------------------------
// tb_cla_group_carry_seq
//
// Drives a default instance (N=16, GROUP=4) and two N=8 instances (GROUP=2 and
// GROUP=8). The expected results come from a directed table and from plain
// integer addition a + b + cin, where G = a & b and P = a ^ b.
// -----------------------------------------------------------------------------
module tb_cla_group_carry_seq;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int nvec = 0;
    int nmis = 0;

    // ---------------- default instance, N=16 GROUP=4 ----------------
    logic        iv, ir, ci, ov, ordy, co, bp;
    logic [15:0] gv, pv, sm;

    cla_group_carry_seq #(.N(16), .GROUP(4)) dut16 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv), .in_ready(ir),
        .generate_value(gv), .propagate(pv), .carry_in(ci),
        .out_valid(ov), .out_ready(ordy),
        .sum(sm), .carry_out(co), .block_prop(bp)
    );

    // ---------------- N=8 instances: [0] GROUP=2, [1] GROUP=8 ----------------
    logic       iv8 [2];
    logic       ir8 [2];
    logic       ci8 [2];
    logic       ov8 [2];
    logic       co8 [2];
    logic       bp8 [2];
    logic [7:0] gv8 [2];
    logic [7:0] pv8 [2];
    logic [7:0] sm8 [2];
    logic       ordy8;

    cla_group_carry_seq #(.N(8), .GROUP(2)) dut8a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv8[0]), .in_ready(ir8[0]),
        .generate_value(gv8[0]), .propagate(pv8[0]), .carry_in(ci8[0]),
        .out_valid(ov8[0]), .out_ready(ordy8),
        .sum(sm8[0]), .carry_out(co8[0]), .block_prop(bp8[0])
    );

    cla_group_carry_seq #(.N(8), .GROUP(8)) dut8b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv8[1]), .in_ready(ir8[1]),
        .generate_value(gv8[1]), .propagate(pv8[1]), .carry_in(ci8[1]),
        .out_valid(ov8[1]), .out_ready(ordy8),
        .sum(sm8[1]), .carry_out(co8[1]), .block_prop(bp8[1])
    );

    typedef struct {
        logic [15:0] g;
        logic [15:0] p;
        logic        cin;
        logic [15:0] exp_sum;
        logic        exp_cout;
        logic        exp_bp;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One operation on the 16-bit instance; called and returns at a negedge.
    task automatic do_op16(input logic [15:0] g, input logic [15:0] p, input logic c,
                           output logic [15:0] s, output logic cout, output logic bpo,
                           output int lat, output int acc);
        int n;
        n = 0;
        while (!ir && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("in_ready_timeout16", ir, 1);
        gv = g; pv = p; ci = c; iv = 1'b1;
        @(negedge clk);
        acc = cyc;
        iv  = 1'b0;
        lat = 0;
        while (!ov && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        if (lat >= 50) chk("out_valid_timeout16", ov, 1);
        s = sm; cout = co; bpo = bp;
    endtask

    task automatic do_op8(input int w, input logic [7:0] g, input logic [7:0] p, input logic c,
                          output logic [7:0] s, output logic cout, output logic bpo,
                          output int lat, output int acc);
        int n;
        n = 0;
        while (!ir8[w] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("in_ready_timeout8", ir8[w], 1);
        gv8[w] = g; pv8[w] = p; ci8[w] = c; iv8[w] = 1'b1;
        @(negedge clk);
        acc = cyc;
        iv8[w] = 1'b0;
        lat = 0;
        while (!ov8[w] && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        if (lat >= 50) chk("out_valid_timeout8", ov8[w], 1);
        s = sm8[w]; cout = co8[w]; bpo = bp8[w];
    endtask

    initial begin
        logic [15:0] s16, a16, b16;
        logic [16:0] ref17;
        logic [7:0]  s8, a8, b8;
        logic [8:0]  ref9;
        logic        c1, b1, cr;
        int          lat, acc, prev_acc;

        tbl[0] = '{16'h0220, 16'h5115, 1'b0, 16'h5555, 1'b0, 1'b0};
        tbl[1] = '{16'h0001, 16'hFFFE, 1'b0, 16'h0000, 1'b1, 1'b0};
        tbl[2] = '{16'h0000, 16'hFFFF, 1'b1, 16'h0000, 1'b1, 1'b1};
        tbl[3] = '{16'h0000, 16'hFFFF, 1'b0, 16'hFFFF, 1'b0, 1'b1};
        tbl[4] = '{16'h0000, 16'h00FF, 1'b1, 16'h0100, 1'b0, 1'b0};
        tbl[5] = '{16'hFFFF, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        tbl[6] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
        tbl[7] = '{16'h8000, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0};

        rst_n = 1'b0;
        iv = 1'b0; gv = '0; pv = '0; ci = 1'b0; ordy = 1'b1;
        ordy8 = 1'b1;
        for (int w = 0; w < 2; w++) begin
            iv8[w] = 1'b0; gv8[w] = '0; pv8[w] = '0; ci8[w] = 1'b0;
        end

        // ---- reset state ----
        repeat (3) @(negedge clk);
        chk("rst_in_ready", ir, 0);
        chk("rst_out_valid", ov, 0);
        chk("rst_sum", sm, 0);
        chk("rst_carry_out", co, 0);
        chk("rst_block_prop", bp, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("in_ready_after_release", ir, 1);
        chk("in_ready8a_after_release", ir8[0], 1);
        chk("in_ready8b_after_release", ir8[1], 1);

        // ---- directed table ----
        for (int i = 0; i < 8; i++) begin
            do_op16(tbl[i].g, tbl[i].p, tbl[i].cin, s16, c1, b1, lat, acc);
            $display("table %0d: g=%h p=%h cin=%b -> sum=%h cout=%b bp=%b lat=%0d",
                     i, tbl[i].g, tbl[i].p, tbl[i].cin, s16, c1, b1, lat);
            chk("table_sum", s16, tbl[i].exp_sum);
            chk("table_cout", c1, tbl[i].exp_cout);
            chk("table_bp", b1, tbl[i].exp_bp);
            chk("table_latency", lat, 4);
            chk("table_in_ready_in_done", ir, 0);
        end
        @(negedge clk);

        // ---- backpressure with ignored input ----
        ordy = 1'b0;
        do_op16(16'h0220, 16'h5115, 1'b0, s16, c1, b1, lat, acc);
        $display("backpressure op: sum=%h cout=%b lat=%0d", s16, c1, lat);
        chk("bp_sum", s16, 16'h5555);
        for (int k = 0; k < 5; k++) begin
            if (k == 1) begin
                gv = 16'h0001; pv = 16'hFFFE; ci = 1'b1; iv = 1'b1;
            end
            if (k == 2) iv = 1'b0;
            @(negedge clk);
            chk("bp_out_valid_held", ov, 1);
            chk("bp_sum_stable", sm, 16'h5555);
            chk("bp_cout_stable", co, 0);
            chk("bp_in_ready_low", ir, 0);
        end
        ordy = 1'b1;
        @(negedge clk);
        chk("bp_release_in_ready", ir, 1);
        chk("bp_release_out_valid", ov, 0);
        repeat (3) begin
            @(negedge clk);
            chk("bp_not_queued", ov, 0);
        end

        // ---- reset mid-CALC ----
        gv = 16'h0000; pv = 16'hFFFF; ci = 1'b0; iv = 1'b1;
        @(negedge clk);
        iv = 1'b0;
        repeat (2) @(negedge clk);
        chk("midcalc_partial_sum", sm, 16'h00FF);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", ov, 0);
        chk("midrst_sum", sm, 0);
        chk("midrst_cout", co, 0);
        chk("midrst_bp", bp, 0);
        chk("midrst_in_ready", ir, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_op16(16'h0000, 16'h00FF, 1'b1, s16, c1, b1, lat, acc);
        $display("after reset op: sum=%h cout=%b lat=%0d", s16, c1, lat);
        chk("postrst_sum", s16, 16'h0100);
        chk("postrst_cout", c1, 0);
        chk("postrst_latency", lat, 4);

        // ---- random sweep, N=16 GROUP=4 ----
        prev_acc = 0;
        for (int i = 0; i < 200; i++) begin
            a16 = 16'($urandom);
            b16 = 16'($urandom);
            cr  = 1'($urandom);
            ref17 = {1'b0, a16} + {1'b0, b16} + {16'b0, cr};
            do_op16(a16 & b16, a16 ^ b16, cr, s16, c1, b1, lat, acc);
            $display("rnd16 %0d: a=%h b=%h cin=%b -> sum=%h cout=%b", i, a16, b16, cr, s16, c1);
            chk("rnd16_sum", s16, ref17[15:0]);
            chk("rnd16_cout", c1, ref17[16]);
            chk("rnd16_bp", b1, ((a16 ^ b16) == 16'hFFFF));
            chk("rnd16_latency", lat, 4);
            if (i > 0) chk("rnd16_spacing", acc - prev_acc, 6);
            prev_acc = acc;
        end

        // ---- random sweeps, N=8 GROUP=2 and N=8 GROUP=8 ----
        for (int w = 0; w < 2; w++) begin
            prev_acc = 0;
            for (int i = 0; i < 200; i++) begin
                a8 = 8'($urandom);
                b8 = 8'($urandom);
                cr = 1'($urandom);
                ref9 = {1'b0, a8} + {1'b0, b8} + {8'b0, cr};
                do_op8(w, a8 & b8, a8 ^ b8, cr, s8, c1, b1, lat, acc);
                $display("rnd8 g%0d %0d: a=%h b=%h cin=%b -> sum=%h cout=%b",
                         (w == 0) ? 2 : 8, i, a8, b8, cr, s8, c1);
                chk("rnd8_sum", s8, ref9[7:0]);
                chk("rnd8_cout", c1, ref9[8]);
                chk("rnd8_bp", b1, ((a8 ^ b8) == 8'hFF));
                chk("rnd8_latency", lat, (w == 0) ? 4 : 1);
                if (i > 0) chk("rnd8_spacing", acc - prev_acc, (w == 0) ? 6 : 3);
                prev_acc = acc;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/cla_group_carry_seq.md
Name: cla_group_carry_seq

Overview:
Sequential carry-lookahead stage directly downstream of the generate/propagate stage. It accepts an N-bit generate vector, an N-bit propagate vector and a carry-in over a valid/ready handshake. It then resolves carries and sum bits one GROUP-bit lookahead slice per clock, under a small controller FSM. It presents the N-bit sum and carry-out on a valid/ready output handshake.

Parameters:
N, 16, operand width in bits; must be a multiple of GROUP.
GROUP, 4, bits resolved per CALC cycle by the in-slice lookahead logic; 1 <= GROUP <= N.

Ports:
clk  input  1  rising-edge clock, the single clock domain
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  upstream has a G/P/carry-in set ready to hand over
in_ready  output  1  block can accept a new operation
generate_value  input  N  per-bit generate, g_i = a_i & b_i
propagate  input  N  per-bit propagate, p_i = a_i ^ b_i
carry_in  input  1  carry into bit 0
out_valid  output  1  sum and carry_out are valid
out_ready  input  1  downstream accepts the result
sum  output  N  result, s_i = p_i ^ c_i
carry_out  output  1  carry out of bit N-1
block_prop  output  1  AND of all propagate bits of the accepted operation

Behaviour:
- Reset: asynchronous on rst_n low.
  - State goes to IDLE; slice index goes to 0.
  - Internal G/P/carry registers go to 0.
  - Output values under reset: in_ready=0 while rst_n low and 1 from the first cycle after release; out_valid=0; sum=0; carry_out=0; block_prop=0.
  - A reset mid-operation discards the in-flight operation and produces no output.
- FSM has three states: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On a clock edge with in_valid=1, the operation is accepted:
    - generate_value, propagate and carry_in are latched.
    - sum is cleared; block_prop is set to the AND of propagate.
    - Slice index goes to 0; state goes to CALC.
- CALC:
  - in_ready=0, out_valid=0.
  - Each cycle processes slice k = index, covering bits [k*GROUP +: GROUP].
  - Carries within the slice use two-level lookahead from the running carry: c_{i+1} = g_i | (p_i & c_i), expanded so there is no ripple inside the slice.
  - The slice's sum bits are written into sum[k*GROUP +: GROUP].
  - The slice carry-out is written to the running carry register.
  - index increments by 1.
  - When k = N/GROUP - 1, the final carry is written to carry_out and state goes to DONE.
- DONE:
  - out_valid=1; sum, carry_out and block_prop are held stable.
  - in_ready=0.
  - On an edge with out_ready=1, state goes to IDLE.
  - out_valid must not drop before the handshake completes.
- Latency: out_valid rises exactly N/GROUP edges after the accepting edge (4 with the defaults).
- Minimum spacing between accepts is N/GROUP + 2 cycles; there is no overlap of operations.
- Inputs:
  - generate_value, propagate and carry_in are sampled only on the accepting edge; changes during CALC or DONE have no effect.
  - in_valid outside IDLE is ignored and is not queued.
- Widths: the index counter is clog2(N/GROUP) bits, minimum 1, and wraps to 0 on DONE entry.
- Outputs are registered; there is no combinational path from any input to any output.
- Upstream must present a consistent vector pair (g_i & p_i = 0). Behaviour otherwise is still defined by the carry equation above.

Test Plan:
- Basic add, defaults (N=16, GROUP=4): A=0x1234, B=0x4321 → G=0x0220, P=0x5115, cin=0 → sum=0x5555, carry_out=0, block_prop=0; out_valid exactly 4 edges after accept.
- Full cross-slice propagation: G=0x0001, P=0xFFFE, cin=0 (0xFFFF+0x0001) → sum=0x0000, carry_out=1.
- Carry-in only: G=0x0000, P=0xFFFF, cin=1 → sum=0x0000, carry_out=1, block_prop=1. The same vectors with cin=0 → sum=0xFFFF, carry_out=0.
- Backpressure and ignored input: hold out_ready=0 for 5 cycles in DONE → out_valid stays 1, sum stable, in_ready=0. Pulse in_valid with new data meanwhile → no effect. After out_ready=1 → IDLE next cycle, in_ready=1.
- Reset mid-CALC: assert rst_n=0 two cycles after accept → out_valid, sum, carry_out, block_prop are 0 immediately. After release, a new operation G=0x0000, P=0x00FF, cin=1 → sum=0x0100, carry_out=0.
- Back-to-back ops with out_ready tied high: accept/complete spacing is 6 cycles; random 200-vector sweep compared against A+B+cin reference. Repeat with N=8, GROUP=2 and N=8, GROUP=8.
